// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch front end: default widths,
// reset PC, PC increment and the packed {pc, inst} fetch entry.
package if_pkg;

   localparam int ADDR_W_DEF  = 32;
   localparam int INST_W_DEF  = 32;
   localparam int PC_STEP_DEF = 4;

   localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;

   // One queued fetch result; pc already carries the +PC_STEP convention.
   typedef struct packed {
      logic [ADDR_W_DEF-1:0] pc;
      logic [INST_W_DEF-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/sync_fifo_flush.sv
// Circular-buffer FIFO with push, pop, synchronous flush and an occupancy
// count. The head word is driven only from stored state (no path from pop_i)
// and reads zero while the FIFO is empty.
module sync_fifo_flush #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           head_o,
   output logic                       valid_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int                PTR_W  = $clog2(DEPTH);
   localparam int                CNT_W  = $clog2(DEPTH+1);
   localparam logic [PTR_W-1:0]  LAST_P = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  FULL_C = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_P) ? '0 : p + PTR_W'(1);
   endfunction

   // Qualify push/pop and compute next pointers and count; flush wins over both.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      do_push  = push_i && !flush_i;
      do_pop   = pop_i && (count_q != '0) && !flush_i;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
         if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; the count gates visibility of stale words.
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign valid_o = (count_q != '0);
   assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
   assign count_o = count_q;

   // The producer's credit scheme must never push into a full queue.
   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(do_push && (count_q == FULL_C) && !do_pop));

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one-cycle-latency
// instruction-memory reads under a credit rule, and queues returned
// {pc+PC_STEP, inst} pairs for ID behind a valid/ready handshake.
// A taken branch flushes the queue and drops the in-flight response.
module if_prefetch_queue
   import if_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                INST_W   = INST_W_DEF,
   parameter int                DEPTH    = 4,
   parameter int                PC_STEP  = PC_STEP_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       branch_taken,
   input  logic [ADDR_W-1:0]          branch_addr,
   output logic                       imem_req,
   output logic [ADDR_W-1:0]          imem_addr,
   input  logic [INST_W-1:0]          imem_rdata,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ADDR_W-1:0]          out_pc,
   output logic [INST_W-1:0]          out_inst,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int                CNT_W   = $clog2(DEPTH+1);
   localparam int                ENTRY_W = ADDR_W + INST_W;
   localparam logic [CNT_W:0]    DEPTH_C = (CNT_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic               inflight_q, inflight_d;
   logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
   logic [CNT_W:0]     used;
   logic               issue;
   logic               push;
   logic [ENTRY_W-1:0] push_data;
   logic [ENTRY_W-1:0] fifo_head;
   logic [CNT_W-1:0]   fifo_count;

   // Credit check: queued plus in-flight entries must leave room; a same-cycle
   // pop earns no credit. Reset is folded in so no request escapes during reset.
   always_comb begin
      used  = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q);
      issue = rst && (used < DEPTH_C) && !branch_taken;
   end

   // Next fetch PC and in-flight tracking; a branch overrides everything.
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      if (branch_taken) begin
         fetch_pc_d = branch_addr;
         inflight_d = 1'b0;
      end else if (issue) begin
         fetch_pc_d    = fetch_pc_q + STEP_C;
         inflight_pc_d = fetch_pc_q;
      end
   end

   // Fetch PC and in-flight state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   // A response is kept only if its request is still live (no redirect this cycle).
   assign push      = inflight_q && !branch_taken;
   assign push_data = {inflight_pc_q + STEP_C, imem_rdata};

   sync_fifo_flush #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk         (clk),
      .rst_n       (rst),
      .flush_i     (branch_taken),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (out_ready),
      .head_o      (fifo_head),
      .valid_o     (out_valid),
      .count_o     (fifo_count)
   );

   assign imem_req  = issue;
   assign imem_addr = fetch_pc_q;
   assign out_pc    = fifo_head[ENTRY_W-1 -: ADDR_W];
   assign out_inst  = fifo_head[INST_W-1:0];
   assign occupancy = fifo_count;

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Parametrised successor to the fixed-width fetch stage plus IF/ID register pair.
- Owns the fetch PC and issues one-cycle-latency instruction-memory reads.
- Buffers returned {pc, instruction} pairs in a DEPTH-entry queue and presents them to ID through a valid/ready handshake.
- Branch redirect flushes the queue and any in-flight read. Backpressure from ID replaces the global freeze wire.

Parameters:
- ADDR_W, 32, PC and memory address width.
- INST_W, 32, instruction word width.
- DEPTH, 4, queue entries; legal range 2..16. Sustained 1 inst/cycle requires DEPTH>=3.
- PC_STEP, 4, PC increment per fetch.
- RESET_PC, 0, fetch PC after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- branch_taken  in  1  redirect request from EXE.
- branch_addr  in  ADDR_W  redirect target.
- imem_req  out  1  read request this cycle.
- imem_addr  out  ADDR_W  read address; valid when imem_req=1.
- imem_rdata  in  INST_W  read data, returned exactly 1 cycle after imem_req.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  ID accepts the head entry.
- out_pc  out  ADDR_W  PC of the head entry, plus PC_STEP (same convention as the existing IF stage).
- out_inst  out  INST_W  instruction of the head entry.
- occupancy  out  clog2(DEPTH+1)  number of queued entries.

Behaviour:
- State:
  - fetch_pc
  - inflight flag and inflight_pc
  - queue storage, head/tail pointers, count
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC, inflight=0, count=0, pointers=0.
  - imem_req=0, out_valid=0, occupancy=0.
  - out_pc and out_inst read 0 while empty.
- Issue rule (combinational):
  - imem_req = (count + inflight < DEPTH) && !branch_taken.
  - imem_addr = fetch_pc.
  - A pop in the same cycle gives no credit.
- On an issue edge: fetch_pc += PC_STEP (wraps modulo 2^ADDR_W), inflight←1, inflight_pc←fetch_pc. Otherwise inflight←0.
- Response:
  - In the cycle after an issue, imem_rdata is valid.
  - If no branch_taken in that cycle, push {inflight_pc+PC_STEP, imem_rdata} at the tail.
- Latency: reset release → first issue in cycle 0 → push at the end of cycle 1 → out_valid=1 in cycle 2.
- Pop: when out_valid && out_ready, head advances. Push and pop in the same cycle leaves count unchanged.
- Pointers wrap modulo DEPTH. Overflow is impossible by the credit rule; an assertion fires if a push occurs at count==DEPTH.
- Pop when empty is ignored.
- Outputs out_valid, out_pc and out_inst come from registered queue state; no combinational path from out_ready to out_*.
- branch_taken=1, effective at the clock edge:
  - count←0, pointers←0.
  - The pending response is discarded.
  - A same-cycle pop is ignored.
  - fetch_pc←branch_addr, inflight←0, no issue that cycle.
  - Next cycle issues branch_addr; first redirected instruction is valid 2 cycles after the branch edge.
- Consecutive branch_taken cycles: the last branch_addr wins. No issue occurs while branch_taken is held.
- Reset asserted mid-operation: everything returns to reset values immediately. A memory response arriving after reset release is ignored because inflight=0.

Decomposition:
- Shared package if_pkg:
  - default ADDR_W/INST_W
  - RESET_PC
  - PC_STEP
  - typedef of the packed fetch entry {pc, inst}
- Sub-module sync_fifo_flush (WIDTH, DEPTH):
  - Circular-buffer FIFO with push, pop, synchronous flush, count, and a registered head.
  - Reusable later for the IF/ID and ID/EXE registers.
- The top level holds only the PC, in-flight tracking and credit logic.

Test Plan:
- Reset then out_ready=1, imem returns addr/4: out_valid rises in cycle 2; out_pc=4,8,12,... with inst=0,1,2, one per cycle; imem_req held at 1.
- out_ready=0 from cycle 0: occupancy saturates at DEPTH=4. imem_req=0 once count+inflight=4, with exactly 4 issues total (addrs 0,4,8,12). Releasing ready drains pcs 4,8,12,16 in order and fetching resumes at 16.
- Branch with queue at 3 entries plus one in flight, branch_addr=0x100: next cycle occupancy=0 and imem_addr=0x100. The stale response is not pushed. Next out_pc=0x104 appears 2 cycles after the branch.
- branch_taken with out_ready=1 and out_valid=1 in the same cycle: the head is not consumed; all old entries are gone.
- Back-to-back branch_taken to 0x200 then 0x300: no request for 0x200; first issue is 0x300.
- rst=0 asserted asynchronously mid-stream with occupancy=2: outputs zero before the next clock edge. After release, fetch restarts at RESET_PC with no stale data.
